// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM encoding, frame geometry
// and the odd-parity helper.
package ps2_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } ps2_state_e;

  localparam int FRAME_BITS         = 11;
  localparam int PS2_TIMEOUT_100MHZ = 20000;

  // Odd parity holds when data and parity bit together carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction
endpackage

// File: rtl/ps2_byte_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO only lands when a
// pop frees the slot in the same cycle, otherwise the byte is dropped.
module ps2_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       ck,
  input  logic                       reset,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty,
  output logic                       drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][7:0] mem_q, mem_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  do_pop, do_push;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign head    = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise and filter the pins, deframe and
// check 11-bit frames, queue good bytes and inhibit the device near full.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = PS2_TIMEOUT_100MHZ,
  parameter int DEPTH       = 8,
  parameter int INHIBIT_LVL = DEPTH - 1
) (
  input  logic                       ck,
  input  logic                       reset,
  input  logic                       ps2_clk_in,
  input  logic                       ps2_data_in,
  output logic                       ps2_clk_oe,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [7:0]                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       busy,
  output logic                       err_parity,
  output logic                       err_frame,
  output logic                       err_timeout,
  output logic                       overflow,
  input  logic                       clr_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int LW = $clog2(DEPTH + 1);

  logic [1:0]  clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic        filt_clk_q, filt_clk_d;
  logic [7:0]  filt_cnt_q, filt_cnt_d;
  logic        fall, data_s;
  ps2_state_e  state_q, state_d;
  logic [9:0]  shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        oe_q, oe_d;
  logic [3:0]  err_q, err_d, err_set;  // {overflow, timeout, frame, parity}
  logic        push, set_frame, set_parity, set_tout, timed_out, par_ok;
  logic        fifo_full, fifo_empty, fifo_drop;

  assign clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
  assign data_sync_d = {data_sync_q[0], ps2_data_in};
  assign data_s      = data_sync_q[1];

  // The filtered clock only follows a level held for FILT_LEN straight samples.
  always_comb begin
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != filt_clk_q) begin
      if (filt_cnt_q == 8'(FILT_LEN - 1)) filt_clk_d = clk_sync_q[1];
      else                                filt_cnt_d = filt_cnt_q + 8'd1;
    end
  end
  assign fall = filt_clk_q && !filt_clk_d;

  assign timed_out = (timer_q == TW'(TIMEOUT_CYC));
  assign par_ok    = odd_parity_ok(shift_q[7:0], shift_q[8]);

  always_ff @(posedge ck or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (fall && !data_s) state_d = ST_RECV;
      ST_RECV: begin
        if (fall) begin
          if (bit_cnt_q == 4'(FRAME_BITS - 1)) state_d = ST_CHECK;
        end else if (timed_out) begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    set_frame  = ((state_q == ST_IDLE) && fall && data_s) ||
                 ((state_q == ST_CHECK) && !shift_q[9]);
    set_parity = (state_q == ST_CHECK) && !par_ok;
    set_tout   = (state_q == ST_RECV) && !fall && timed_out;
    push       = (state_q == ST_CHECK) && shift_q[9] && par_ok;
  end

  // Shifter fills from the top so D0 ends in bit 0 and the stop bit in bit 9.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    timer_d   = timer_q;
    case (state_q)
      ST_IDLE: if (fall && !data_s) begin
        bit_cnt_d = 4'd1;
        timer_d   = '0;
      end
      ST_RECV: if (fall) begin
        shift_d   = {data_s, shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
        timer_d   = '0;
      end else begin
        timer_d   = timer_q + TW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    err_set = {fifo_drop, set_tout, set_frame, set_parity};
    err_d   = err_set | (err_q & {4{~clr_err}});
    if (oe_q) oe_d = (level >= LW'(INHIBIT_LVL));
    else      oe_d = (state_q == ST_IDLE) && !fall && (level >= LW'(INHIBIT_LVL));
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_clk_q  <= 1'b1;
      filt_cnt_q  <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      timer_q     <= '0;
      oe_q        <= 1'b0;
      err_q       <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_clk_q  <= filt_clk_d;
      filt_cnt_q  <= filt_cnt_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      timer_q     <= timer_d;
      oe_q        <= oe_d;
      err_q       <= err_d;
    end
  end

  ps2_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .ck        (ck),
    .reset     (reset),
    .push      (push),
    .push_data (shift_q[7:0]),
    .pop       (rd_en),
    .head      (rd_data),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign rd_valid    = !fifo_empty;
  assign ps2_clk_oe  = oe_q;
  assign err_parity  = err_q[0];
  assign err_frame   = err_q[1];
  assign err_timeout = err_q[2];
  assign overflow    = err_q[3];
endmodule
